exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_exec_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl.sv
// Execution controller for a slow-clocked teaching core: free-run, single-step and
// one-bit breakpoint control, all expressed as a one-cycle cpu_en strobe.
module exec_ctrl #(
  parameter int SLOW_RATE = 20_000_000,
  parameter int DEBOUNCE  = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       bp_en,
  input  logic       bp_pc,
  input  logic       pc,
  output logic       cpu_en,
  output logic       running,
  output logic       halted,
  output logic       heartbeat,
  output logic [7:0] cycles
);

  localparam int PS_W = (SLOW_RATE > 2) ? $clog2(SLOW_RATE) : 1;
  localparam int DB_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(SLOW_RATE - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } state_t;

  logic [3:0]      sync1_q, sync1_d;
  logic [3:0]      sync2_q, sync2_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            step_db_q, step_db_d;
  logic            step_db_dly_q, step_db_dly_d;
  state_t          state_q, state_d;
  logic            ret_brk_q, ret_brk_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic            bp_chk_q, bp_chk_d;
  logic            cpu_en_q, cpu_en_d;
  logic            running_q, running_d;
  logic            halted_q, halted_d;
  logic            heartbeat_q, heartbeat_d;
  logic [7:0]      cycles_q, cycles_d;

  logic run_s, step_s, bp_en_s, bp_pc_s;
  logic run_next_s;
  logic step_pulse_s;
  logic bp_hit_s;

  assign run_s      = sync2_q[3];
  assign step_s     = sync2_q[2];
  assign bp_en_s    = sync2_q[1];
  assign bp_pc_s    = sync2_q[0];
  // run_s as it will read in the next cycle; lets cpu_en be registered yet still
  // suppressed in a RUN exit cycle.
  assign run_next_s = sync1_q[3];

  assign step_pulse_s = step_db_q & ~step_db_dly_q;
  assign bp_hit_s     = bp_chk_q & bp_en_s & (pc == bp_pc_s);

  // Two-flop synchronizers for the switch/button inputs.
  always_comb begin
    sync1_d = {run, step, bp_en, bp_pc};
    sync2_d = sync1_q;
  end

  // Step debouncer: accept a new level only after DEBOUNCE consecutive differing cycles.
  always_comb begin
    step_db_d     = step_db_q;
    db_cnt_d      = '0;
    step_db_dly_d = step_db_q;
    if (step_s != step_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        step_db_d = step_s;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d  = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Next-state logic for the execution FSM.
  always_comb begin
    state_d   = state_q;
    ret_brk_d = ret_brk_q;
    case (state_q)
      IDLE: begin
        if (run_s) begin
          state_d = RUN;
        end else if (step_pulse_s) begin
          state_d   = STEP;
          ret_brk_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The breakpoint check wins over a simultaneous run switch release.
        if (bp_hit_s) begin
          state_d = BREAK;
        end else if (!run_s) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      STEP: begin
        if (ret_brk_q) begin
          state_d = BREAK;
        end else begin
          state_d = IDLE;
        end
      end
      BREAK: begin
        if (step_pulse_s) begin
          state_d   = STEP;
          ret_brk_d = 1'b1;
        end else if (!run_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d   = IDLE;
        ret_brk_d = 1'b0;
      end
    endcase
  end

  // Prescaler, strobe and status outputs, all computed one cycle ahead.
  always_comb begin
    presc_d = '0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      if (presc_q == PS_LAST) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PS_W'(1);
      end
    end else begin
      presc_d = '0;
    end

    cpu_en_d    = ((state_d == RUN) && (presc_d == PS_LAST) && run_next_s) ||
                  (state_d == STEP);
    bp_chk_d    = cpu_en_q && (state_q == RUN);
    running_d   = (state_d == RUN);
    halted_d    = (state_d == BREAK);
    heartbeat_d = heartbeat_q ^ cpu_en_q;

    if (cpu_en_q && (cycles_q != 8'd255)) begin
      cycles_d = cycles_q + 8'd1;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 4'd0;
      sync2_q       <= 4'd0;
      db_cnt_q      <= '0;
      step_db_q     <= 1'b0;
      step_db_dly_q <= 1'b0;
      state_q       <= IDLE;
      ret_brk_q     <= 1'b0;
      presc_q       <= '0;
      bp_chk_q      <= 1'b0;
      cpu_en_q      <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
      heartbeat_q   <= 1'b0;
      cycles_q      <= 8'd0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_cnt_q      <= db_cnt_d;
      step_db_q     <= step_db_d;
      step_db_dly_q <= step_db_dly_d;
      state_q       <= state_d;
      ret_brk_q     <= ret_brk_d;
      presc_q       <= presc_d;
      bp_chk_q      <= bp_chk_d;
      cpu_en_q      <= cpu_en_d;
      running_q     <= running_d;
      halted_q      <= halted_d;
      heartbeat_q   <= heartbeat_d;
      cycles_q      <= cycles_d;
    end
  end

  assign cpu_en    = cpu_en_q;
  assign running   = running_q;
  assign halted    = halted_q;
  assign heartbeat = heartbeat_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Randomised scoreboard bench for exec_ctrl with a behavioural model of the controller
// and a small core model that toggles pc on every cpu_en strobe.
`timescale 1ns/1ps
module tb_exec_ctrl;
  localparam int SR = 4;
  localparam int DB = 3;

  logic       clock = 1'b0;
  logic       reset, run, step, bp_en, bp_pc, pc;
  logic       cpu_en, running, halted, heartbeat;
  logic [7:0] cycles;

  exec_ctrl #(.SLOW_RATE(SR), .DEBOUNCE(DB)) dut (
    .clock(clock), .reset(reset), .run(run), .step(step), .bp_en(bp_en),
    .bp_pc(bp_pc), .pc(pc), .cpu_en(cpu_en), .running(running), .halted(halted),
    .heartbeat(heartbeat), .cycles(cycles)
  );

  always #5 clock = ~clock;

  typedef struct { int cyc; int cnt; int hb; int run; int brk; } exp_t;
  typedef enum {M_OFF, M_FREE, M_SINGLE, M_STOPPED} mode_e;

  exp_t  q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc_n    = 0;
  bit    en_seen  = 1'b0;
  bit    prev_en  = 1'b0;
  bit    run_i, step_i, bpen_i, bppc_i, rst_i;

  // Reference model state: mode, cycles spent in free-run, debounced level, history.
  mode_e     m_mode;
  int        m_k, m_cyc, m_diff;
  bit        m_after, m_ret_brk, m_pc, m_hb, m_db, m_db_prev;
  bit [3:0]  h1, h2;
  int        now_cnt, now_hb, now_run, now_brk;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF; m_k = 0; m_cyc = 0; m_diff = 0;
    m_after = 1'b0; m_ret_brk = 1'b0; m_pc = 1'b0; m_hb = 1'b0;
    m_db = 1'b0; m_db_prev = 1'b0; h1 = 4'd0; h2 = 4'd0;
    now_cnt = 0; now_hb = 0; now_run = 0; now_brk = 0;
  endtask

  task automatic model_step();
    bit    rs, ss, bs, ps, sp, pulse;
    mode_e nxt;
    exp_t  e;
    rs = h2[3]; ss = h2[2]; bs = h2[1]; ps = h2[0];
    sp = m_db && !m_db_prev;
    pulse = 1'b0;
    nxt = m_mode;
    now_run = (m_mode == M_FREE);
    now_brk = (m_mode == M_STOPPED);
    now_cnt = m_cyc;
    now_hb  = m_hb;
    case (m_mode)
      M_OFF: begin
        if (rs) begin nxt = M_FREE; m_k = 0; end
        else if (sp) begin nxt = M_SINGLE; m_ret_brk = 1'b0; end
      end
      M_FREE: begin
        m_k++;
        if (m_after && bs && (m_pc == ps)) nxt = M_STOPPED;
        else if (!rs) nxt = M_OFF;
        else if (m_k % SR == 0) pulse = 1'b1;
      end
      M_SINGLE: begin
        pulse = 1'b1;
        nxt = m_ret_brk ? M_STOPPED : M_OFF;
      end
      M_STOPPED: begin
        if (sp) begin nxt = M_SINGLE; m_ret_brk = 1'b1; end
        else if (!rs) nxt = M_OFF;
      end
      default: nxt = M_OFF;
    endcase
    if (pulse) begin
      e.cyc = cyc_n; e.cnt = m_cyc; e.hb = m_hb; e.run = now_run; e.brk = now_brk;
      q.push_back(e);
      if (m_cyc < 255) m_cyc++;
      m_hb = ~m_hb;
      m_pc = ~m_pc;
    end
    m_after = pulse && (m_mode == M_FREE);
    m_db_prev = m_db;
    if (ss != m_db) begin
      m_diff++;
      if (m_diff == DB) begin m_db = ss; m_diff = 0; end
    end else begin
      m_diff = 0;
    end
    h2 = h1;
    h1 = {run, step, bp_en, bp_pc};
    m_mode = nxt;
  endtask

  // One clock: drive inputs just after the edge, then let the model predict this cycle.
  task automatic tick();
    @(posedge clock);
    cyc_n++;
    #1;
    if (!rst_i) pc = 1'b0;
    else if (en_seen) pc = ~pc;
    reset = rst_i; run = run_i; step = step_i; bp_en = bpen_i; bp_pc = bppc_i;
    #2;
    if (!rst_i) model_reset();
    else model_step();
  endtask

  task automatic assert_reset();
    #1;
    reset = 1'b0; rst_i = 1'b0; pc = 1'b0;
    model_reset();
    q.delete();
  endtask

  task automatic release_reset();
    tick(); tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic press_step(int hi, int lo);
    step_i = 1'b1; repeat (hi) tick();
    step_i = 1'b0; repeat (lo) tick();
  endtask

  // Monitor: pops a prediction whenever the DUT strobes cpu_en.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      en_seen = 1'b0;
      prev_en = 1'b0;
    end else begin
      en_seen = cpu_en;
      while (q.size() > 0 && q[0].cyc < cyc_n) begin
        chk("cpu_en_missing", 0, 1);
        void'(q.pop_front());
      end
      chk("running_state", running, now_run);
      chk("halted_state", halted, now_brk);
      if (cpu_en) begin
        chk("no_back_to_back", prev_en, 0);
        if (q.size() == 0 || q[0].cyc != cyc_n) begin
          chk("unexpected_cpu_en_cycle", cyc_n, (q.size() > 0) ? q[0].cyc : -1);
        end else begin
          e = q.pop_front();
          chk("cycles_at_pulse", cycles, e.cnt);
          chk("heartbeat_at_pulse", heartbeat, e.hb);
          chk("running_at_pulse", running, e.run);
          chk("halted_at_pulse", halted, e.brk);
        end
      end
      prev_en = cpu_en;
    end
  end

  initial begin
    int st_hold;
    reset = 1'b0; run = 1'b0; step = 1'b0; bp_en = 1'b0; bp_pc = 1'b0; pc = 1'b0;
    run_i = 1'b0; step_i = 1'b0; bpen_i = 1'b0; bppc_i = 1'b0; rst_i = 1'b0;
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("reset_cpu_en", cpu_en, 0);
    chk("reset_running", running, 0);
    chk("reset_halted", halted, 0);
    chk("reset_heartbeat", heartbeat, 0);
    chk("reset_cycles", cycles, 0);
    release_reset();

    // Free run for 44 cycles
    run_i = 1'b1;
    repeat (44) tick();
    chk("run_cycles", cycles, now_cnt);
    chk("run_cycles_spec", cycles, 10);
    chk("run_running", running, 1);
    chk("run_heartbeat", heartbeat, now_hb);
    run_i = 1'b0;
    repeat (6) tick();
    chk("run_stop_running", running, 0);

    // Bouncy step press gives exactly one strobe
    assert_reset(); release_reset();
    for (int i = 0; i < 10; i++) begin
      step_i = ~step_i;
      repeat ($urandom_range(1, 2)) tick();
    end
    step_i = 1'b0; tick();
    press_step(6, 6);
    repeat (6) tick();
    chk("bounce_cycles", cycles, now_cnt);
    chk("bounce_cycles_spec", cycles, 1);
    chk("bounce_idle_running", running, 0);
    chk("bounce_idle_halted", halted, 0);

    // Breakpoint on pc==1
    assert_reset(); release_reset();
    bpen_i = 1'b1; bppc_i = 1'b1; run_i = 1'b1;
    repeat (32) tick();
    chk("bp_halted", halted, 1);
    chk("bp_running", running, 0);
    chk("bp_cycles", cycles, 1);

    // Single step out of BREAK and back
    press_step(6, 8);
    chk("bp_step_halted", halted, 1);
    chk("bp_step_cycles", cycles, now_cnt);
    chk("bp_step_cycles_spec", cycles, 2);
    run_i = 1'b0;
    repeat (5) tick();
    chk("bp_exit_halted", halted, 0);
    chk("bp_exit_running", running, 0);
    bpen_i = 1'b0; bppc_i = 1'b0;

    // Saturation, then reset mid-RUN and restart
    assert_reset(); release_reset();
    run_i = 1'b1;
    repeat (1100) tick();
    chk("sat_cycles", cycles, 255);
    chk("sat_running", running, 1);
    assert_reset();
    #0.5;
    chk("midrst_cpu_en", cpu_en, 0);
    chk("midrst_running", running, 0);
    chk("midrst_heartbeat", heartbeat, 0);
    chk("midrst_cycles", cycles, 0);
    release_reset();
    repeat (20) tick();
    chk("restart_cycles", cycles, now_cnt);
    chk("restart_heartbeat", heartbeat, now_hb);

    // Random soak with occasional resets
    st_hold = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) run_i = ~run_i;
      if ($urandom_range(0, 59) == 0) bpen_i = ~bpen_i;
      if ($urandom_range(0, 24) == 0) bppc_i = ~bppc_i;
      st_hold--;
      if (st_hold <= 0) begin
        step_i = ~step_i;
        st_hold = $urandom_range(1, 6);
      end
      tick();
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        release_reset();
      end
    end
    chk("soak_cycles", cycles, now_cnt);
    chk("soak_heartbeat", heartbeat, now_hb);
    run_i = 1'b0; step_i = 1'b0;
    repeat (12) tick();
    chk("pending_pulses", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
